// File: rtl/icmp_tx_payload_reader.sv
// -----------------------------------------------------------------------------
// icmp_tx_payload_reader
//
// Reader side of the ICMP echo-request payload RAM. On a start pulse it reads
// pay_len bytes (clamped to the RAM capacity) from address 0 upward and streams
// them to the ICMP echo-reply frame builder over a valid/ready byte stream.
// When ICMP_TX_CSUM_EN is defined, it also produces the folded 16-bit
// one's-complement sum of the payload for the reply checksum.
//
// Optional feature macro: ICMP_TX_CSUM_EN
//   defined   : csum/csum_valid carry the payload sum, presented with done
//   undefined : csum/csum_valid are tied to 0, no accumulator is built
//
// Ports
//   wr_clk       in   clock (RAM read clock is the same clock)
//   tb_wr_rst    in   asynchronous active-high reset
//   start        in   1-cycle pulse, begin streaming from address 0
//   pay_len      in   payload byte count, sampled on start, clamped to 2**ADDR_WIDTH
//   busy         out  transfer in progress
//   done         out  1-cycle pulse after the last byte (or a zero-length start)
//   ram_rd_addr  out  registered RAM read address
//   ram_rd_data  in   RAM read data, valid one cycle after ram_rd_addr
//   tx_data      out  payload byte
//   tx_valid     out  tx_data valid
//   tx_last      out  final byte marker
//   tx_ready     in   downstream accept
//   csum         out  folded one's-complement payload sum (not inverted)
//   csum_valid   out  csum valid, from done until the next start
// -----------------------------------------------------------------------------
module icmp_tx_payload_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 9
) (
   input  logic                  wr_clk,
   input  logic                  tb_wr_rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  pay_len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   input  logic                  tx_ready,
   output logic [15:0]           csum,
   output logic                  csum_valid
);

   // Elaboration-time parameter sanity checks.
   if (DATA_WIDTH != 8) begin : g_data_width_check
      $error("icmp_tx_payload_reader: DATA_WIDTH must be 8");
   end
   if (LEN_WIDTH < ADDR_WIDTH + 1) begin : g_len_width_check
      $error("icmp_tx_payload_reader: LEN_WIDTH must hold 2**ADDR_WIDTH");
   end

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam int SKID_DEPTH = 2;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

   logic [1:0]            state_reg;
   logic [LEN_WIDTH-1:0]  len_reg;
   logic [LEN_WIDTH-1:0]  rd_cnt_reg;
   logic [LEN_WIDTH-1:0]  out_cnt_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   // addr_pend_reg: an address was registered last edge, the RAM samples it
   //                on the coming edge.
   // data_pend_reg: that read's data is on ram_rd_data this cycle.
   logic                  addr_pend_reg;
   logic                  data_pend_reg;
   logic [1:0]            skid_cnt_reg;
   logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] skid_reg;
   logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] skid_next;

   logic                  in_stream;
   logic [LEN_WIDTH-1:0]  len_clamp;
   logic                  hs;
   logic                  last_beat;
   logic                  take_direct;
   logic                  push;
   logic                  pop;
   logic [1:0]            wr_idx;
   logic [1:0]            skid_cnt_next;
   logic [2:0]            occupancy;
   logic                  issue;

   assign in_stream = (state_reg == ST_STREAM);
   assign len_clamp = (pay_len > MAX_LEN) ? MAX_LEN : pay_len;

   // Output side: the skid head has priority; when the buffer is empty the
   // returning RAM word is presented directly so the first byte costs no
   // extra cycle and the stream runs at one byte per cycle.
   assign tx_valid  = in_stream & ((skid_cnt_reg != 2'd0) | data_pend_reg);
   assign tx_data   = (!tx_valid)                ? '0 :
                      (skid_cnt_reg != 2'd0)     ? skid_reg[0] : ram_rd_data;
   assign last_beat = (out_cnt_reg == (len_reg - LEN_WIDTH'(1)));
   assign tx_last   = tx_valid & last_beat;
   assign hs        = tx_valid & tx_ready;

   // A returning word that is not consumed straight through is captured.
   // If it was offered and stalled, capturing it keeps tx_data stable because
   // the output mux then switches to the identical buffered copy.
   assign take_direct   = hs & (skid_cnt_reg == 2'd0) & data_pend_reg;
   assign push          = in_stream & data_pend_reg & ~take_direct;
   assign pop           = hs & (skid_cnt_reg != 2'd0);
   assign wr_idx        = skid_cnt_reg - {1'b0, pop};
   assign skid_cnt_next = skid_cnt_reg + {1'b0, push} - {1'b0, pop};

   // Outstanding bytes = buffered + both read pipeline stages, less the byte
   // leaving this cycle. Issuing only while that is below the buffer depth
   // guarantees every returning word has a slot, even under full stall.
   assign occupancy = {1'b0, skid_cnt_reg} + {2'b00, addr_pend_reg} + {2'b00, data_pend_reg};
   assign issue     = in_stream & (rd_cnt_reg < len_reg) &
                      (occupancy < (3'd2 + {2'b00, hs}));

   // Skid entries shift toward the head on a pop; a push lands in the first
   // free slot after that shift.
   for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
      logic [DATA_WIDTH-1:0] shift_src;
      if (gi < SKID_DEPTH - 1) begin : g_mid
         assign shift_src = skid_reg[gi+1];
      end else begin : g_tail
         assign shift_src = skid_reg[gi];
      end
      assign skid_next[gi] = (push && (wr_idx == 2'(gi))) ? ram_rd_data :
                             pop                          ? shift_src   : skid_reg[gi];
   end

   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         rd_cnt_reg    <= '0;
         out_cnt_reg   <= '0;
         addr_reg      <= '0;
         addr_pend_reg <= 1'b0;
         data_pend_reg <= 1'b0;
         skid_cnt_reg  <= 2'd0;
         skid_reg      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  len_reg       <= len_clamp;
                  rd_cnt_reg    <= '0;
                  out_cnt_reg   <= '0;
                  addr_pend_reg <= 1'b0;
                  data_pend_reg <= 1'b0;
                  skid_cnt_reg  <= 2'd0;
                  state_reg     <= (len_clamp == '0) ? ST_DONE : ST_STREAM;
               end
            end
            ST_STREAM: begin
               skid_reg      <= skid_next;
               skid_cnt_reg  <= skid_cnt_next;
               addr_pend_reg <= issue;
               data_pend_reg <= addr_pend_reg;
               if (issue) begin
                  addr_reg   <= rd_cnt_reg[ADDR_WIDTH-1:0];
                  rd_cnt_reg <= rd_cnt_reg + LEN_WIDTH'(1);
               end
               if (hs) begin
                  out_cnt_reg <= out_cnt_reg + LEN_WIDTH'(1);
                  if (last_beat) begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = in_stream;
   assign done        = (state_reg == ST_DONE);
   assign ram_rd_addr = addr_reg;

`ifdef ICMP_TX_CSUM_EN
   // Big-endian byte pairing: even-index bytes are held as the high half,
   // odd-index bytes complete the word. An odd final byte is added with a
   // zero low half. The running sum is folded every step (end-around carry).
   logic [DATA_WIDTH-1:0] hi_reg;
   logic [15:0]           acc_reg;
   logic                  csum_valid_reg;
   logic [15:0]           word;
   logic [16:0]           sum17;
   logic                  add_en;

   assign word   = out_cnt_reg[0] ? {hi_reg, tx_data} : {tx_data, 8'h00};
   assign sum17  = {1'b0, acc_reg} + {1'b0, word};
   assign add_en = hs & (out_cnt_reg[0] | last_beat);

   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         hi_reg         <= '0;
         acc_reg        <= '0;
         csum_valid_reg <= 1'b0;
      end else if ((state_reg == ST_IDLE) && start) begin
         acc_reg        <= '0;
         csum_valid_reg <= (len_clamp == '0);
      end else if (hs) begin
         if (!out_cnt_reg[0]) begin
            hi_reg <= tx_data;
         end
         if (add_en) begin
            acc_reg <= sum17[15:0] + {15'd0, sum17[16]};
         end
         if (last_beat) begin
            csum_valid_reg <= 1'b1;
         end
      end
   end

   assign csum       = csum_valid_reg ? acc_reg : 16'h0000;
   assign csum_valid = csum_valid_reg;
`else
   assign csum       = 16'h0000;
   assign csum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_icmp_tx_payload_reader.sv
// -----------------------------------------------------------------------------
// tb_icmp_tx_payload_reader
//
// Self-checking bench for icmp_tx_payload_reader. A behavioural RAM with
// one-cycle registered read feeds the DUT. Expected bytes are queued when a
// transfer is started and popped on every tx handshake; latency, gap-free
// streaming, stall stability, done timing and the payload checksum are
// checked against values computed here from the RAM contents.
// -----------------------------------------------------------------------------
module tb_icmp_tx_payload_reader;

   logic        wr_clk;
   logic        tb_wr_rst;
   logic        start;
   logic [8:0]  pay_len;
   logic        busy;
   logic        done;
   logic [7:0]  ram_rd_addr;
   logic [7:0]  ram_rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready;
   logic [15:0] csum;
   logic        csum_valid;

   icmp_tx_payload_reader dut (
      .wr_clk      (wr_clk),
      .tb_wr_rst   (tb_wr_rst),
      .start       (start),
      .pay_len     (pay_len),
      .busy        (busy),
      .done        (done),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_last     (tx_last),
      .tx_ready    (tx_ready),
      .csum        (csum),
      .csum_valid  (csum_valid)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   // Payload RAM, registered read, read latency 1.
   logic [7:0] mem [256];
   always_ff @(posedge wr_clk) ram_rd_data <= mem[ram_rd_addr];

   int assert_cnt = 0;
   int fail_cnt   = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: {last, data}
   logic [8:0] exp_q[$];

   int cyc = 0;
   initial forever begin
      @(posedge wr_clk);
      cyc++;
   end

   // tx_ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
   int ready_mode = 0;
   int ready_ph   = 0;
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge wr_clk);
         #2;
         tx_ready = (ready_mode == 0) ? 1'b1 : ((ready_ph % 3) == 0);
         ready_ph++;
      end
   end

   // Monitor state
   int          hs_cnt;
   int          first_valid_cyc;
   int          first_hs_cyc;
   int          last_hs_cyc;
   int          done_cnt;
   int          done_cyc;
   logic        done_busy;
   logic [15:0] done_csum;
   logic        done_csv;
   logic        stall_pend = 1'b0;
   logic [7:0]  stall_data;
   logic        stall_last;

   initial forever begin
      @(negedge wr_clk);
      if (!tb_wr_rst) begin
         if (stall_pend) begin
            check_value("stall_valid", tx_valid, 1);
            check_value("stall_data", tx_data, stall_data);
            check_value("stall_last", tx_last, stall_last);
         end
         if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (tx_valid && tx_ready) begin
            logic [8:0] e;
            check_value("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_value("tx_data", tx_data, e[7:0]);
               check_value("tx_last", tx_last, e[8]);
               $display("byte %0d: data=0x%02h last=%0b cyc=%0d", hs_cnt, tx_data, tx_last, cyc);
            end
            if (hs_cnt == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
         end
         stall_pend = tx_valid && !tx_ready;
         stall_data = tx_data;
         stall_last = tx_last;
         if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
            done_csum = csum;
            done_csv  = csum_valid;
         end
      end else begin
         stall_pend = 1'b0;
      end
   end

   function automatic logic [15:0] model_csum(input int len);
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < len; i += 2) begin
         s += {16'h0, mem[i], (i + 1 < len) ? mem[i+1] : 8'h00};
      end
      while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return s[15:0];
   endfunction

   task automatic check_all_zero(input string where);
      check_value({where, "_busy"}, busy, 0);
      check_value({where, "_done"}, done, 0);
      check_value({where, "_addr"}, ram_rd_addr, 0);
      check_value({where, "_tx_valid"}, tx_valid, 0);
      check_value({where, "_tx_data"}, tx_data, 0);
      check_value({where, "_tx_last"}, tx_last, 0);
      check_value({where, "_csum"}, csum, 0);
      check_value({where, "_csum_valid"}, csum_valid, 0);
   endtask

   // Run one transfer. restart_at>0: pulse start again after that many
   // handshakes. rst_at>0: assert reset after that many handshakes.
   task automatic run_xfer(input logic [8:0] plen, input int rmode,
                           input int restart_at, input int rst_at);
      int  len;
      int  start_edge;
      bit  restarted;
      bit  rst_done;
      len       = (plen > 9'd256) ? 256 : int'(plen);
      restarted = 0;
      rst_done  = 0;
      @(posedge wr_clk);
      #1;
      hs_cnt = 0; done_cnt = 0; first_valid_cyc = -1;
      first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
      ready_mode = rmode;
      ready_ph   = 0;
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), mem[i]});
      start      = 1'b1;
      pay_len    = plen;
      start_edge = cyc + 1;
      @(posedge wr_clk);
      #1;
      start = 1'b0;
      check_value("busy_after_start", busy, len > 0);
      for (int c = 0; c < len * 4 + 20 && done_cnt == 0 && !rst_done; c++) begin
         @(posedge wr_clk);
         #1;
         if (restart_at > 0 && hs_cnt == restart_at && !restarted) begin
            start     = 1'b1;
            pay_len   = 9'd9;
            restarted = 1;
         end else begin
            start = 1'b0;
         end
         if (rst_at > 0 && hs_cnt == rst_at) begin
            tb_wr_rst = 1'b1;
            #1;
            check_all_zero("midrst");
            exp_q.delete();
            rst_done = 1;
         end
      end
      start = 1'b0;
      if (rst_done) begin
         @(posedge wr_clk);
         #1;
         tb_wr_rst = 1'b0;
      end
      repeat (5) @(posedge wr_clk);
      #1;
      check_value("done_count", done_cnt, rst_done ? 0 : 1);
      check_value("queue_empty", exp_q.size(), 0);
      if (!rst_done) begin
         if (len > 0) begin
            check_value("first_valid_latency", first_valid_cyc - start_edge, 2);
            if (rmode == 0) check_value("no_gaps", last_hs_cyc - first_hs_cyc, len - 1);
            check_value("done_latency", done_cyc, last_hs_cyc + 1);
         end else begin
            check_value("no_bytes", hs_cnt, 0);
            check_value("no_valid", first_valid_cyc, -1);
            check_value("done_latency_zero", done_cyc, start_edge);
         end
         check_value("busy_at_done", done_busy, 0);
`ifdef ICMP_TX_CSUM_EN
         check_value("csum_valid", done_csv, 1);
         check_value("csum", done_csum, model_csum(len));
`else
         check_value("csum_valid_off", done_csv, 0);
         check_value("csum_off", done_csum, 0);
`endif
      end
      $display("xfer pay_len=%0d mode=%0d bytes=%0d done=%0d csum=0x%04h", plen, rmode, hs_cnt, done_cnt, done_csum);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tb_wr_rst = 1'b1;
      start     = 1'b0;
      pay_len   = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (3) @(negedge wr_clk);
      check_all_zero("reset");
      @(posedge wr_clk);
      #1;
      tb_wr_rst = 1'b0;

      // Three bytes, always ready; csum 0x0402.
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
      run_xfer(9'd3, 0, 0, 0);

      // Full RAM, descending pattern, then an over-range length that clamps.
      for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
      run_xfer(9'd256, 0, 0, 0);
      run_xfer(9'd300, 0, 0, 0);

      // Random contents under 1,0,0 backpressure, even and odd lengths.
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      run_xfer(9'd8, 1, 0, 0);
      run_xfer(9'd7, 1, 0, 0);

      // Zero length.
      run_xfer(9'd0, 0, 0, 0);

      // Second start mid-transfer is ignored.
      run_xfer(9'd4, 0, 2, 0);

      // Reset at byte 5 of 10, then a fresh 2-byte transfer.
      run_xfer(9'd10, 0, 0, 5);
      run_xfer(9'd2, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
